// File: rtl/tile_addr_gen_pkg.sv
// ---------------------------------------------------------------------------
// tile_addr_gen_pkg
//   Shared types and elaboration-time helpers for the tile read-address
//   generator: FSM state encoding, the AXI INCR burst code, and the functions
//   that turn the map/tile geometry into tile sizes, burst counts and tile
//   counts for a given stride.
// ---------------------------------------------------------------------------
package tile_addr_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DATA = 2'd2,
        ST_WAIT_RES  = 2'd3
    } state_t;

    localparam logic [1:0] ARBURST_INCR = 2'b01;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // Input pixels spanned by one tile in one dimension.
    function automatic int tile_span(input int po, input int ksize, input int s);
        return (po - 1) * s + ksize;
    endfunction

    // Bursts needed to cover one tile row.
    function automatic int n_bursts(input int tw, input int burst);
        return ceil_div(tw, burst);
    endfunction

    // Tiles needed along one dimension of the map.
    function automatic int n_tiles(input int isz, input int ksize, input int s, input int po);
        return ceil_div((isz - ksize) / s + 1, po);
    endfunction

endpackage

// File: rtl/tile_addr_gen_outst_cnt.sv
// ---------------------------------------------------------------------------
// outst_cnt
//   Count of AXI read bursts issued but not yet completed.
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset
//     inc         AR handshake this cycle
//     dec         rlast this cycle
//     cnt         current outstanding count
//     full        cnt == MAX_OUTST
//     zero        cnt == 0
//     underflow   dec while zero (the dec is dropped)
// ---------------------------------------------------------------------------
module outst_cnt
    import tile_addr_gen_pkg::*;
#(
    parameter int MAX_OUTST = 4,
    parameter int CNT_W     = $clog2(MAX_OUTST + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             full,
    output logic             zero,
    output logic             underflow
);

    logic dec_ok;

    assign zero      = (cnt == '0);
    assign full      = (cnt == CNT_W'(MAX_OUTST));
    assign underflow = dec && zero;
    assign dec_ok    = dec && !zero;

    // Simultaneous inc and a valid dec cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && !dec_ok) begin
            cnt <= cnt + CNT_W'(1);
        end else if (dec_ok && !inc) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/tile_addr_gen.sv
// ---------------------------------------------------------------------------
// tile_addr_gen
//   Input-buffer read-address generator for the conv engine. Walks the input
//   map tile by tile and, for each tile, issues one AXI INCR burst per
//   (channel, row, row-segment), bounded by MAX_OUTST outstanding bursts.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     init_addr_en    start-of-map pulse (honoured only in IDLE)
//     init_addr       map base byte address
//     stride_sel      0 = stride 1, 1 = stride 2
//     arvalid/arready AXI read-address handshake
//     araddr, arlen   burst start byte address, beats-1
//     arburst         constant INCR
//     rlast           one pulse per completed burst
//     result_valid    compute engine finished the current tile
//     blkend          pulse: all data of the current tile returned
//     mapend          pulse: last tile of the map consumed
//     busy            FSM not idle
//     err             sticky: rlast seen with nothing outstanding
// ---------------------------------------------------------------------------
module tile_addr_gen
    import tile_addr_gen_pkg::*;
#(
    parameter int AW        = 32,
    parameter int KSIZE     = 3,
    parameter int POX       = 16,
    parameter int POY       = 3,
    parameter int IW        = 224,
    parameter int IH        = 224,
    parameter int CH        = 4,
    parameter int PIX_BYTES = 1,
    parameter int BURST     = 16,
    parameter int MAX_OUTST = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          init_addr_en,
    input  logic [AW-1:0] init_addr,
    input  logic          stride_sel,
    output logic          arvalid,
    input  logic          arready,
    output logic [AW-1:0] araddr,
    output logic [7:0]    arlen,
    output logic [1:0]    arburst,
    input  logic          rlast,
    input  logic          result_valid,
    output logic          blkend,
    output logic          mapend,
    output logic          busy,
    output logic          err
);

    localparam int CW   = 16;
    localparam int OC_W = $clog2(MAX_OUTST + 1);

    localparam int TW1  = tile_span(POX, KSIZE, 1);
    localparam int TW2  = tile_span(POX, KSIZE, 2);
    localparam int TH1  = tile_span(POY, KSIZE, 1);
    localparam int TH2  = tile_span(POY, KSIZE, 2);
    localparam int NB1  = n_bursts(TW1, BURST);
    localparam int NB2  = n_bursts(TW2, BURST);
    localparam int NTX1 = n_tiles(IW, KSIZE, 1, POX);
    localparam int NTX2 = n_tiles(IW, KSIZE, 2, POX);
    localparam int NTY1 = n_tiles(IH, KSIZE, 1, POY);
    localparam int NTY2 = n_tiles(IH, KSIZE, 2, POY);

    localparam logic [CW-1:0] CH_M1    = CW'(CH - 1);
    localparam logic [7:0]    LEN_FULL = 8'(BURST - 1);
    localparam logic [7:0]    LEN_LST1 = 8'(TW1 - (NB1 - 1) * BURST - 1);
    localparam logic [7:0]    LEN_LST2 = 8'(TW2 - (NB2 - 1) * BURST - 1);
    localparam logic [OC_W-1:0] OUTST_M1 = OC_W'(MAX_OUTST - 1);

    state_t        state;
    logic          s2_q;
    logic [AW-1:0] base_q;
    logic [CW-1:0] c_q, r_q, b_q, tx_q, ty_q;
    logic          res_flag_q;

    logic [CW-1:0] nb_m1, th_m1, ntx_m1, nty_m1;
    logic [7:0]    len_last;
    logic          b_last, r_last, c_last, tile_done_hs;
    logic [CW-1:0] b_nx, r_nx, c_nx;
    logic [CW-1:0] sel_c, sel_r, sel_b;
    logic          ar_hs;
    logic [AW-1:0] ld_addr;
    logic [7:0]    ld_len;

    logic [OC_W-1:0] outst;
    logic            outst_full, outst_zero, underflow;
    logic            can_chain, drain_done;

    function automatic logic [AW-1:0] burst_addr(
        input logic [AW-1:0] b_base,
        input logic          s2,
        input logic [CW-1:0] xt,
        input logic [CW-1:0] yt,
        input logic [CW-1:0] cc,
        input logic [CW-1:0] rr,
        input logic [CW-1:0] bb
    );
        logic [AW-1:0] x0, y0, row, pix;
        x0 = AW'(xt) * AW'(POX);
        y0 = AW'(yt) * AW'(POY);
        if (s2) begin
            x0 = x0 << 1;
            y0 = y0 << 1;
        end
        row = AW'(cc) * AW'(IH) + y0 + AW'(rr);
        pix = row * AW'(IW) + x0 + AW'(bb) * AW'(BURST);
        return b_base + pix * AW'(PIX_BYTES);
    endfunction

    outst_cnt #(
        .MAX_OUTST (MAX_OUTST),
        .CNT_W     (OC_W)
    ) u_outst (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (ar_hs),
        .dec       (rlast),
        .cnt       (outst),
        .full      (outst_full),
        .zero      (outst_zero),
        .underflow (underflow)
    );

    assign arburst = ARBURST_INCR;
    assign busy    = (state != ST_IDLE);
    assign ar_hs   = arvalid && arready;

    assign nb_m1    = s2_q ? CW'(NB2 - 1)  : CW'(NB1 - 1);
    assign th_m1    = s2_q ? CW'(TH2 - 1)  : CW'(TH1 - 1);
    assign ntx_m1   = s2_q ? CW'(NTX2 - 1) : CW'(NTX1 - 1);
    assign nty_m1   = s2_q ? CW'(NTY2 - 1) : CW'(NTY1 - 1);
    assign len_last = s2_q ? LEN_LST2 : LEN_LST1;

    // Burst order: segment fastest, then row, then channel.
    assign b_last       = (b_q == nb_m1);
    assign r_last       = (r_q == th_m1);
    assign c_last       = (c_q == CH_M1);
    assign tile_done_hs = b_last && r_last && c_last;
    assign b_nx = b_last ? '0 : b_q + CW'(1);
    assign r_nx = b_last ? (r_last ? '0 : r_q + CW'(1)) : r_q;
    assign c_nx = (b_last && r_last) ? (c_last ? '0 : c_q + CW'(1)) : c_q;

    // On a handshake the AR registers are reloaded with the following burst,
    // otherwise with the burst the counters currently point at.
    assign sel_c   = ar_hs ? c_nx : c_q;
    assign sel_r   = ar_hs ? r_nx : r_q;
    assign sel_b   = ar_hs ? b_nx : b_q;
    assign ld_addr = burst_addr(base_q, s2_q, tx_q, ty_q, sel_c, sel_r, sel_b);
    assign ld_len  = (sel_b == nb_m1) ? len_last : LEN_FULL;

    // Back-to-back issue only while the post-handshake count stays below the
    // limit; a concurrent rlast is ignored here, which is merely conservative.
    assign can_chain  = (outst < OUTST_M1);
    assign drain_done = outst_zero || ((outst == OC_W'(1)) && rlast);

    always_ff @(posedge clk) begin
        if (state == ST_IDLE && init_addr_en) begin
            base_q <= init_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            s2_q       <= 1'b0;
            c_q        <= '0;
            r_q        <= '0;
            b_q        <= '0;
            tx_q       <= '0;
            ty_q       <= '0;
            res_flag_q <= 1'b0;
            arvalid    <= 1'b0;
            araddr     <= '0;
            arlen      <= '0;
            blkend     <= 1'b0;
            mapend     <= 1'b0;
            err        <= 1'b0;
        end else begin
            blkend <= 1'b0;
            mapend <= 1'b0;
            if (underflow) begin
                err <= 1'b1;
            end

            // A result pulse arriving in the same cycle as consumption is
            // kept for the next tile.
            if (state != ST_IDLE) begin
                if (state == ST_WAIT_RES && res_flag_q) begin
                    res_flag_q <= result_valid;
                end else if (result_valid) begin
                    res_flag_q <= 1'b1;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (init_addr_en) begin
                        s2_q       <= stride_sel;
                        c_q        <= '0;
                        r_q        <= '0;
                        b_q        <= '0;
                        tx_q       <= '0;
                        ty_q       <= '0;
                        res_flag_q <= 1'b0;
                        state      <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    if (arvalid) begin
                        if (arready) begin
                            c_q <= c_nx;
                            r_q <= r_nx;
                            b_q <= b_nx;
                            if (tile_done_hs) begin
                                arvalid <= 1'b0;
                                state   <= ST_WAIT_DATA;
                            end else if (can_chain) begin
                                araddr <= ld_addr;
                                arlen  <= ld_len;
                            end else begin
                                arvalid <= 1'b0;
                            end
                        end
                    end else if (!outst_full) begin
                        arvalid <= 1'b1;
                        araddr  <= ld_addr;
                        arlen   <= ld_len;
                    end
                end

                ST_WAIT_DATA: begin
                    if (drain_done) begin
                        blkend <= 1'b1;
                        state  <= ST_WAIT_RES;
                    end
                end

                ST_WAIT_RES: begin
                    if (res_flag_q) begin
                        if (tx_q == ntx_m1 && ty_q == nty_m1) begin
                            mapend <= 1'b1;
                            tx_q   <= '0;
                            ty_q   <= '0;
                            state  <= ST_IDLE;
                        end else if (tx_q == ntx_m1) begin
                            tx_q  <= '0;
                            ty_q  <= ty_q + CW'(1);
                            state <= ST_ISSUE;
                        end else begin
                            tx_q  <= tx_q + CW'(1);
                            state <= ST_ISSUE;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
